mod2011_chunk_accumulator: RTL and testbench

Sequential modular accumulator downstream of the per-chunk residue LUT bank for modulus 2011. Each LUT turns one 6-bit slice of the 300-bit operand into an 11-bit partial residue. This block accepts those partial residues one per handshake, sums them modulo 2011, and after NCHUNK of them presents the final 11-bit residue of the full operand. Input and output use valid/ready handshakes. Only one reduction is in flight at a time.

---
 rtl/mod2011_chunk_accumulator_if.sv | 23 ++
 rtl/mod2011_chunk_accumulator.sv | 82 ++++++++
 tb/tb_mod2011_chunk_accumulator.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/mod2011_chunk_accumulator_if.sv
// Handshake bundle between the residue LUT bank, the chunk accumulator and its consumer.
// slave is the accumulator's view; master is the view of whatever drives it.
interface mod2011_chunk_accumulator_if #(
    parameter int W = 11
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         err;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_res, err
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_res, err
    );
endinterface

// File: rtl/mod2011_chunk_accumulator.sv
// Sums NCHUNK partial residues modulo MOD, one per in handshake, then presents the final residue.
// Latency: result valid the cycle after the last chunk is accepted; one operand per NCHUNK+1 cycles best case.
// Backpressure: in_ready drops while a result is held; the result holds until out_ready.
module mod2011_chunk_accumulator #(
    parameter int MOD    = 2011,
    parameter int W      = 11,
    parameter int NCHUNK = 50
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mod2011_chunk_accumulator_if.slave  acc_bus
);
    localparam int              CW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [W:0]      MOD_S = (W+1)'(MOD);
    localparam logic [W-1:0]    MOD_N = W'(MOD);
    localparam logic [CW-1:0]   LAST  = CW'(NCHUNK - 1);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_acc;
    logic [W-1:0]    r_res;
    logic [CW-1:0]   r_cnt;
    logic            r_vld;
    logic            r_err;

    logic            w_accept;
    logic            w_oor;
    logic [W:0]      w_sum;
    logic [W-1:0]    w_acc_nxt;

    assign w_accept  = acc_bus.in_valid && (r_state == ST_ACC);
    assign w_oor     = acc_bus.in_data >= MOD_N;
    // One extra bit keeps the carry; a single subtract is exact for in-range inputs.
    assign w_sum     = {1'b0, r_acc} + {1'b0, acc_bus.in_data};
    assign w_acc_nxt = (w_sum >= MOD_S) ? W'(w_sum - MOD_S) : W'(w_sum);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_ACC;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_res   <= '0;
            r_vld   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_err <= r_err | w_oor;
                        if (r_cnt == LAST) begin
                            r_res   <= w_acc_nxt;
                            r_vld   <= 1'b1;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_state <= ST_DONE;
                        end else begin
                            r_acc <= w_acc_nxt;
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (acc_bus.out_ready) begin
                        r_vld   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= ST_ACC;
                    end
                end
                default: r_state <= ST_ACC;
            endcase
        end
    end

    assign acc_bus.in_ready  = (r_state == ST_ACC);
    assign acc_bus.out_valid = r_vld;
    assign acc_bus.out_res   = r_res;
    assign acc_bus.err       = r_err;
endmodule

// File: tb/tb_mod2011_chunk_accumulator.sv
// Scoreboard bench: the stimulus thread queues expected residues, a monitor pops them on each output handshake.
module tb_mod2011_chunk_accumulator;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mod2011_chunk_accumulator_if #(.W(11)) bus ();

    mod2011_chunk_accumulator #(.MOD(2011), .W(11), .NCHUNK(50)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .acc_bus (bus)
    );

    typedef struct {
        logic [10:0] res;
        logic        err;
        bit          chk_res;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rnd_rdy = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push(input int res, input logic err, input bit chk);
        exp_t e;
        e.res = 11'(res);
        e.err = err;
        e.chk_res = chk;
        q.push_back(e);
    endtask

    // Returns #1 after the edge on which d was accepted.
    task automatic send(input logic [10:0] d, input int gap);
        int t;
        bus.in_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        t = 0;
        while (!bus.in_ready && t < 300) begin @(posedge clk); #1; t++; end
        if (!bus.in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout got in_ready=0 expected 1 within 300 cycles");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_const(input logic [10:0] v, input int n);
        for (int i = 0; i < n; i++) send(v, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 3000) begin @(posedge clk); #1; t++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout got %0d pending expected 0", q.size());
        end
    endtask

    // Monitor: a handshake seen at negedge completes on the following rising edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output got res=%0d expected no output", bus.out_res);
                end else begin
                    e = q.pop_front();
                    if (e.chk_res) check("out_res", int'(bus.out_res), int'(e.res));
                    check("out_err", int'(bus.err), int'(e.err));
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        int          sum;
        logic [10:0] vals [50];

        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.out_ready = 1'b0;
        #12;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_res", int'(bus.out_res), 0);
        check("rst_err", int'(bus.err), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        bus.out_ready = 1'b1;
        push(50, 1'b0, 1'b1);
        send_const(11'd1, 50);
        drain();

        push(1961, 1'b0, 1'b1);
        send_const(11'd2010, 50);
        drain();

        push(0, 1'b0, 1'b1);
        send(11'd2010, 0);
        send(11'd1, 0);
        check("wrap_acc_zero", int'(dut.r_acc), 0);
        send_const(11'd0, 48);
        drain();

        // Backpressure: result held while out_ready is low and in_valid is asserted.
        bus.out_ready = 1'b0;
        push(250, 1'b0, 1'b1);
        send_const(11'd5, 50);
        bus.in_valid = 1'b1;
        bus.in_data = 11'd5;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", int'(bus.in_ready), 0);
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_out_res", int'(bus.out_res), 250);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_back", int'(bus.in_ready), 1);
        check("bp_out_valid_drop", int'(bus.out_valid), 0);
        push(350, 1'b0, 1'b1);
        send_const(11'd7, 50);
        drain();

        // Reset after 20 accepts; out_res still holds 350 beforehand.
        send_const(11'd9, 20);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_out_res", int'(bus.out_res), 0);
        check("mid_rst_err", int'(bus.err), 0);
        check("mid_rst_acc", int'(dut.r_acc), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        push(150, 1'b0, 1'b1);
        send_const(11'd3, 50);
        drain();

        bus.out_ready = 1'b0;
        push(0, 1'b1, 1'b0);
        send(11'd2047, 0);
        send_const(11'd0, 49);
        for (int i = 0; i < 3; i++) begin
            check("oor_err_held", int'(bus.err), 1);
            check("oor_valid_held", int'(bus.out_valid), 1);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain();
        check("oor_err_cleared", int'(bus.err), 0);
        push(200, 1'b0, 1'b1);
        send_const(11'd4, 50);
        drain();

        rnd_rdy = 1;
        for (int op = 0; op < 300; op++) begin
            sum = 0;
            for (int i = 0; i < 50; i++) begin
                vals[i] = 11'($urandom_range(0, 2010));
                sum = (sum + int'(vals[i])) % 2011;
            end
            push(sum, 1'b0, 1'b1);
            for (int i = 0; i < 50; i++)
                send(vals[i], ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            bus.in_valid = 1'b0;
        end
        drain();
        rnd_rdy = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
